// File: rtl/ps2_host_ctrl_if.sv
// Command/status handshake between the PS/2 host controller and the keyboard decode logic.
interface ps2_host_ctrl_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       busy;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_done, tx_err, rx_valid, rx_data, rx_err, busy
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_done, tx_err, rx_valid, rx_data, rx_err, busy
    );
endinterface

// File: rtl/ps2_host_ctrl.sv
// PS/2 host controller: receives device frames and sends host commands over the shared
// open-drain clock/data pair, pulling lines low through the OE outputs only.
module ps2_host_ctrl #(
    parameter int INHIBIT_CYCLES = 100,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic ps2_clk_oe,
    output logic ps2_dat_oe,
    ps2_host_ctrl_if.slave host
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CNT_MAX);

    typedef enum logic [2:0] {IDLE, RX, INHIBIT, TX, ACK, WAITIDLE} state_t;
    state_t state, state_nxt;

    logic             clk_p0, clk_p1, clk_p2, dat_p0, dat_p1;
    logic             fe, lines_idle, in_frame, timeout;
    logic             start_rx, grant_tx, rx_shift, tx_shift;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bcnt;
    logic [8:0]       tx_sh;
    logic [8:0]       rx_sh;
    logic             rx_start, tx_dat_oe;
    logic             rx_valid_q, rx_err_q, tx_done_q, tx_err_q;
    logic [7:0]       rx_data_q;

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    // rx_sh holds {parity, data}; a good frame has an odd count of ones across both
    function automatic logic frame_ok(input logic [8:0] sh, input logic stop, input logic start);
        return (^sh) & stop & ~start;
    endfunction

    // Stage p0/p1: two-flop synchronizers, p2: previous synced clock for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            clk_p2 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk_i;
            clk_p1 <= clk_p0;
            clk_p2 <= clk_p1;
            dat_p0 <= ps2_dat_i;
            dat_p1 <= dat_p0;
        end
    end

    assign fe         = clk_p2 & ~clk_p1;
    assign lines_idle = clk_p1 & dat_p1;
    assign in_frame   = state inside {RX, TX, ACK};
    assign timeout    = in_frame && !fe && (cnt == TMO_LAST);
    assign start_rx   = (state == IDLE) && fe && !dat_p1;
    assign grant_tx   = (state == IDLE) && !fe && host.tx_valid && lines_idle;
    assign rx_shift   = (state == RX) && fe && (bcnt != 4'd10);
    assign tx_shift   = (state == TX) && fe && (bcnt != 4'd9);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_rx) state_nxt = RX;
                      else if (grant_tx) state_nxt = INHIBIT;
            RX:       if (timeout) state_nxt = WAITIDLE;
                      else if (fe && bcnt == 4'd10) state_nxt = IDLE;
            INHIBIT:  if (cnt == INH_LAST) state_nxt = TX;
            TX:       if (timeout) state_nxt = WAITIDLE;
                      else if (fe && bcnt == 4'd9) state_nxt = ACK;
            ACK:      if (timeout || fe) state_nxt = WAITIDLE;
            WAITIDLE: if (lines_idle) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ps2_clk_oe    = 1'b0;
        ps2_dat_oe    = 1'b0;
        host.tx_ready = 1'b0;
        host.busy     = (state != IDLE);
        case (state)
            IDLE:    host.tx_ready = grant_tx;
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = (cnt == INH_LAST);
            end
            TX:      ps2_dat_oe = tx_dat_oe;
            default: ;
        endcase
    end

    // Control: timers, bit counter, drive level and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            bcnt       <= '0;
            rx_start   <= 1'b1;
            tx_dat_oe  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;

            // Inhibit timing shares this counter, so clock edges only clear it mid-frame
            if ((state_nxt != state) || (fe && in_frame)) cnt <= '0;
            else if (cnt != CNT_FULL)                     cnt <= cnt + 1'b1;

            case (state)
                IDLE: if (start_rx) begin
                    bcnt     <= 4'd1;
                    rx_start <= dat_p1;
                end
                RX: if (timeout) begin
                    rx_err_q <= 1'b1;
                end else if (fe) begin
                    if (bcnt == 4'd10) begin
                        if (frame_ok(rx_sh, dat_p1, rx_start)) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_sh[7:0];
                        end else begin
                            rx_err_q <= 1'b1;
                        end
                    end else begin
                        bcnt <= bcnt + 4'd1;
                    end
                end
                INHIBIT: if (cnt == INH_LAST) begin
                    tx_dat_oe <= 1'b1;
                    bcnt      <= '0;
                end
                TX: if (timeout) begin
                    tx_err_q <= 1'b1;
                end else if (tx_shift) begin
                    tx_dat_oe <= ~tx_sh[0];
                    bcnt      <= bcnt + 4'd1;
                end else if (fe) begin
                    tx_dat_oe <= 1'b0;
                end
                ACK: if (timeout || (fe && dat_p1)) tx_err_q <= 1'b1;
                     else if (fe)                   tx_done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Data: receive and transmit shift registers
    always_ff @(posedge clk) begin
        if (grant_tx)      tx_sh <= {odd_par(host.tx_data), host.tx_data};
        else if (tx_shift) tx_sh <= {1'b1, tx_sh[8:1]};
        if (rx_shift)      rx_sh <= {dat_p1, rx_sh[8:1]};
    end

    assign host.rx_valid = rx_valid_q;
    assign host.rx_err   = rx_err_q;
    assign host.tx_done  = tx_done_q;
    assign host.tx_err   = tx_err_q;
    assign host.rx_data  = rx_data_q;
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl with an open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic dev_clk, dev_dat;
    logic clk_line, dat_line;
    logic ps2_clk_oe, ps2_dat_oe;

    int n_tests = 0;
    int n_fail  = 0;

    int n_rxv = 0, n_rxe = 0, n_txd = 0, n_txe = 0, n_rdy = 0, n_rdy_busy = 0;
    int n_multi = 0, n_inh_both = 0, inh_run = 0, last_inh = 0, cyc = 0;
    int t_rxv = 0, t_rdy = 0;
    logic [7:0] last_rx = 8'h00;

    ps2_host_ctrl_if bus();

    assign clk_line = dev_clk & ~ps2_clk_oe;
    assign dat_line = dev_dat & ~ps2_dat_oe;

    ps2_host_ctrl #(.INHIBIT_CYCLES(100), .TIMEOUT_CYCLES(2000)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_i  (clk_line),
        .ps2_dat_i  (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .host       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

    // Event monitor, sampled 1 ns after each falling system-clock edge
    always @(negedge clk) begin
        #1;
        cyc++;
        if (bus.rx_valid) begin n_rxv++; last_rx = bus.rx_data; t_rxv = cyc; end
        if (bus.rx_err)  n_rxe++;
        if (bus.tx_done) n_txd++;
        if (bus.tx_err)  n_txe++;
        if (bus.tx_ready) begin n_rdy++; t_rdy = cyc; if (bus.busy) n_rdy_busy++; end
        if ((int'(bus.rx_valid) + int'(bus.rx_err) + int'(bus.tx_done) + int'(bus.tx_err)) > 1) n_multi++;
        if (ps2_clk_oe && ps2_dat_oe) n_inh_both++;
        if (ps2_clk_oe) inh_run++;
        else if (inh_run != 0) begin last_inh = inh_run; inh_run = 0; end
    end

    task automatic dev_send(input logic [10:0] frame, input logic req, output logic at2, output logic at3);
        at2 = 1'b0;
        at3 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            dev_dat = frame[i];
            repeat (20) @(negedge clk);
            dev_clk = 1'b0;
            if (i == 0 && req) begin
                repeat (2) @(negedge clk);
                bus.tx_data  = 8'hA5;
                bus.tx_valid = 1'b1;
                repeat (38) @(negedge clk);
            end else if (i == 10) begin
                repeat (2) @(negedge clk);
                #1 at2 = bus.rx_valid | bus.rx_err;
                @(negedge clk);
                #1 at3 = bus.rx_valid | bus.rx_err;
                repeat (37) @(negedge clk);
            end else begin
                repeat (40) @(negedge clk);
            end
            dev_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
        dev_dat = 1'b1;
    endtask

    task automatic req_tx(input logic [7:0] d, output logic ok);
        int r0;
        ok = 1'b0;
        r0 = n_rdy;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (n_rdy != r0) begin ok = 1'b1; break; end
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_tx_start(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (!ps2_clk_oe && ps2_dat_oe) begin ok = 1'b1; break; end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic dev_bit(input int low_cycles);
        dev_clk = 1'b0;
        repeat (low_cycles) @(negedge clk);
        dev_clk = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic dev_recv(input logic ack, output logic [7:0] d, output logic par, output logic stp,
                            output logic ok);
        d = 8'h00; par = 1'b0; stp = 1'b0;
        wait_tx_start(ok);
        if (ok) begin
            for (int k = 1; k <= 11; k++) begin
                if (k == 11) begin dev_dat = ack; repeat (10) @(negedge clk); end
                dev_clk = 1'b0;
                repeat (40) @(negedge clk);
                dev_clk = 1'b1;
                #1;
                if (k <= 8)       d[k-1] = dat_line;
                else if (k == 9)  par    = dat_line;
                else if (k == 10) stp    = dat_line;
                repeat (40) @(negedge clk);
            end
            dev_dat = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; dev_clk = 1'b1; dev_dat = 1'b1;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
        repeat (5) @(negedge clk);
        #1;
        n_tests++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe got %b want 0", ps2_clk_oe); end
        n_tests++; if (ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dat_oe got %b want 0", ps2_dat_oe); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", bus.rx_data); end
        n_tests++;
        if ({bus.rx_valid, bus.rx_err, bus.tx_done, bus.tx_err, bus.tx_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pulses got %b want 00000",
                     {bus.rx_valid, bus.rx_err, bus.tx_done, bus.tx_err, bus.tx_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_rx_good();
        int v0 = n_rxv, e0 = n_rxe;
        logic at2, at3;
        dev_send({1'b1, 1'b1, 8'h05, 1'b0}, 1'b0, at2, at3);
        repeat (10) @(negedge clk);
        #1;
        n_tests++; if (n_rxv - v0 != 1) begin n_fail++; $display("FAIL rx_good_valid count got %0d want 1", n_rxv - v0); end
        n_tests++; if (n_rxe - e0 != 0) begin n_fail++; $display("FAIL rx_good_err count got %0d want 0", n_rxe - e0); end
        n_tests++; if (bus.rx_data !== 8'h05) begin n_fail++; $display("FAIL rx_good_data got %h want 05", bus.rx_data); end
        n_tests++; if (last_rx !== 8'h05) begin n_fail++; $display("FAIL rx_good_pulse_data got %h want 05", last_rx); end
        n_tests++; if ({at2, at3} !== 2'b01) begin n_fail++; $display("FAIL rx_latency got %b want 01", {at2, at3}); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rx_good_idle busy got %b want 0", bus.busy); end
    endtask

    task automatic test_rx_bad_parity();
        int v0 = n_rxv, e0 = n_rxe;
        logic at2, at3;
        dev_send({1'b1, 1'b0, 8'h05, 1'b0}, 1'b0, at2, at3);
        repeat (10) @(negedge clk);
        #1;
        n_tests++; if (n_rxe - e0 != 1) begin n_fail++; $display("FAIL rx_par_err count got %0d want 1", n_rxe - e0); end
        n_tests++; if (n_rxv - v0 != 0) begin n_fail++; $display("FAIL rx_par_valid count got %0d want 0", n_rxv - v0); end
        n_tests++; if (bus.rx_data !== 8'h05) begin n_fail++; $display("FAIL rx_par_hold got %h want 05", bus.rx_data); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rx_par_idle busy got %b want 0", bus.busy); end
    endtask

    task automatic test_tx_ack(input logic ack);
        int r0 = n_rdy, b0 = n_inh_both, d0 = n_txd, e0 = n_txe;
        logic ok, okr, par, stp;
        logic [7:0] d;
        req_tx(8'hED, okr);
        dev_recv(ack, d, par, stp, ok);
        repeat (10) @(negedge clk);
        #1;
        n_tests++; if (!okr || n_rdy - r0 != 1) begin n_fail++; $display("FAIL tx_ready count got %0d want 1", n_rdy - r0); end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL tx_start_bit got none want dat_oe=1 at clock release"); end
        if (!ack) begin
            n_tests++; if (last_inh != 100) begin n_fail++; $display("FAIL tx_inhibit_len got %0d want 100", last_inh); end
            n_tests++; if (n_inh_both - b0 != 1) begin n_fail++; $display("FAIL tx_start_overlap got %0d want 1", n_inh_both - b0); end
            n_tests++; if (d !== 8'hED) begin n_fail++; $display("FAIL tx_data_bits got %h want ED", d); end
            n_tests++; if ({par, stp} !== 2'b11) begin n_fail++; $display("FAIL tx_par_stop got %b want 11", {par, stp}); end
        end
        n_tests++; if (n_txd - d0 != (ack ? 0 : 1)) begin n_fail++; $display("FAIL tx_done count got %0d want %0d", n_txd - d0, ack ? 0 : 1); end
        n_tests++; if (n_txe - e0 != (ack ? 1 : 0)) begin n_fail++; $display("FAIL tx_err count got %0d want %0d", n_txe - e0, ack ? 1 : 0); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL tx_end_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_tx_timeout();
        int d0 = n_txd, e0 = n_txe, el = 0;
        logic ok, okr, c_oe = 1'b1, d_oe = 1'b1;
        req_tx(8'h3C, okr);
        wait_tx_start(ok);
        for (int k = 1; k <= 3; k++) dev_bit(40);
        dev_clk = 1'b0;
        for (int i = 1; i <= 2600; i++) begin
            @(negedge clk);
            #1;
            if (i == 40) dev_clk = 1'b1;
            if (bus.tx_err) begin el = i; c_oe = ps2_clk_oe; d_oe = ps2_dat_oe; break; end
        end
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        n_tests++; if (!okr || !ok) begin n_fail++; $display("FAIL tmo_setup got ready=%b start=%b want 1 1", okr, ok); end
        n_tests++; if (el < 1998 || el > 2008) begin n_fail++; $display("FAIL tmo_delay got %0d want about 2003", el); end
        n_tests++; if ({c_oe, d_oe} !== 2'b00) begin n_fail++; $display("FAIL tmo_release got %b want 00", {c_oe, d_oe}); end
        n_tests++; if (n_txe - e0 != 1 || n_txd - d0 != 0) begin n_fail++; $display("FAIL tmo_pulses got err=%0d done=%0d want 1 0", n_txe - e0, n_txd - d0); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle busy got %b want 0", bus.busy); end
    endtask

    task automatic test_simultaneous();
        int v0 = n_rxv, r0 = n_rdy, d0 = n_txd;
        logic at2, at3, ok, par, stp;
        logic [7:0] d;
        dev_send({1'b1, 1'b0, 8'h1C, 1'b0}, 1'b1, at2, at3);
        bus.tx_valid = 1'b0;
        dev_recv(1'b0, d, par, stp, ok);
        repeat (10) @(negedge clk);
        #1;
        n_tests++; if (n_rxv - v0 != 1 || last_rx !== 8'h1C) begin n_fail++; $display("FAIL sim_rx got n=%0d data=%h want 1 1c", n_rxv - v0, last_rx); end
        n_tests++; if (n_rdy - r0 != 1) begin n_fail++; $display("FAIL sim_ready count got %0d want 1", n_rdy - r0); end
        n_tests++; if (!(t_rdy > t_rxv)) begin n_fail++; $display("FAIL sim_order got ready@%0d rx@%0d want ready after rx", t_rdy, t_rxv); end
        n_tests++; if (!ok || d !== 8'hA5 || {par, stp} !== 2'b11) begin n_fail++; $display("FAIL sim_tx got %h par=%b stop=%b want a5 1 1", d, par, stp); end
        n_tests++; if (n_txd - d0 != 1) begin n_fail++; $display("FAIL sim_done count got %0d want 1", n_txd - d0); end
    endtask

    task automatic test_reset_mid_tx();
        int p0;
        logic ok, okr, pre;
        req_tx(8'h52, okr);
        wait_tx_start(ok);
        for (int k = 1; k <= 3; k++) dev_bit(40);
        dev_clk = 1'b0;
        repeat (10) @(negedge clk);
        #1 pre = ps2_dat_oe;
        p0 = n_rxv + n_rxe + n_txd + n_txe;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_tests++; if (!okr || !ok || pre !== 1'b1) begin n_fail++; $display("FAIL rst_mid_setup got dat_oe=%b want 1", pre); end
        n_tests++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_release got %b want 00", {ps2_clk_oe, ps2_dat_oe}); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
        @(negedge clk);
        reset = 1'b0;
        dev_clk = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        n_tests++; if (n_rxv + n_rxe + n_txd + n_txe != p0) begin n_fail++; $display("FAIL rst_mid_pulses got %0d want 0", n_rxv + n_rxe + n_txd + n_txe - p0); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle busy got %b want 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_rx_good();
        test_rx_bad_parity();
        test_tx_ack(1'b0);
        test_tx_ack(1'b1);
        test_tx_timeout();
        test_simultaneous();
        test_reset_mid_tx();
        n_tests++; if (n_multi != 0) begin n_fail++; $display("FAIL pulse_exclusive got %0d overlaps want 0", n_multi); end
        n_tests++; if (n_rdy_busy != 0) begin n_fail++; $display("FAIL ready_while_busy got %0d want 0", n_rdy_busy); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
